flopr: RTL and testbench

- Generic parameterized pipeline register with asynchronous active-high reset.
- Used between pipeline stages (e.g. execute→memory) to hold a flat, packed bundle of stage signals.
- Captures `d` on every rising clock edge and presents it on `q`.
- No enable, no stall, no flush port; flush is achieved only through `reset`.

---
 rtl/flopr_pkg.sv | 19 +
 rtl/flopr_stage.sv | 40 ++++
 rtl/flopr.sv | 51 +++++
 tb/tb_flopr.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/flopr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flopr_pkg
// Description : Shared defaults and parameter legality helper for the
//               flopr pipeline register and its single-stage building block.
// Revision    : 1.0 - initial release
// ============================================================================
package flopr_pkg;

    localparam int FLOPR_DEFAULT_WIDTH  = 8;
    localparam int FLOPR_DEFAULT_STAGES = 1;

    // True when the requested geometry describes a real register chain.
    function automatic bit flopr_params_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/flopr_stage.sv
`default_nettype none
// ============================================================================
// Module      : flopr_stage
// Description : One WIDTH-bit register with asynchronous active-high reset.
//               Loads RESET_VALUE on reset, otherwise captures i_d on every
//               rising clk edge.
// Ports       : clk     - rising-edge clock
//               reset   - asynchronous reset, active-high
//               i_d     - data to capture
//               o_q     - registered data
// Revision    : 1.0 - initial release
// ============================================================================
module flopr_stage
    import flopr_pkg::*;
#(
    parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset is tested first, so an edge that arrives while reset is still
    // high never captures data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= RESET_VALUE;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/flopr.sv
`default_nettype none
// ============================================================================
// Module      : flopr
// Description : Parameterised pipeline register. A chain of STAGES
//               flopr_stage registers carries a flat packed bundle from d to
//               q; q is d delayed by STAGES rising clk edges. Reset
//               asynchronously forces every stage to RESET_VALUE.
// Ports       : clk     - rising-edge clock
//               reset   - asynchronous reset, active-high
//               d       - WIDTH-bit data in
//               q       - WIDTH-bit data out (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module flopr
    import flopr_pkg::*;
#(
    parameter int               WIDTH       = FLOPR_DEFAULT_WIDTH,
    parameter int               STAGES      = FLOPR_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!flopr_params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("flopr: WIDTH (%0d) and STAGES (%0d) must both be >= 1", WIDTH, STAGES);
    end

    // w_chain[k] is the input of stage k; w_chain[STAGES] is the output.
    logic [WIDTH-1:0] w_chain [0:STAGES];

    assign w_chain[0] = d;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        flopr_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .i_d   (w_chain[gi]),
            .o_q   (w_chain[gi+1])
        );
    end

    assign q = w_chain[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_flopr.sv
`default_nettype none
// ============================================================================
// Module      : tb_flopr
// Description : Directed self-checking bench for flopr. Four instances cover
//               the default register, a 108-bit bundle, a 3-stage pipeline
//               and a non-zero reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flopr;

    logic clk;

    logic         rst_a;
    logic [7:0]   d_a;
    logic [7:0]   q_a;

    logic         rst_w;
    logic [107:0] d_w;
    logic [107:0] q_w;

    logic         rst_p;
    logic [15:0]  d_p;
    logic [15:0]  q_p;

    logic         rst_f;
    logic [7:0]   d_f;
    logic [7:0]   q_f;

    int n_cmp;
    int n_bad;

    flopr #(.WIDTH(8)) dut_a (
        .clk (clk), .reset (rst_a), .d (d_a), .q (q_a)
    );

    flopr #(.WIDTH(108), .STAGES(1)) dut_w (
        .clk (clk), .reset (rst_w), .d (d_w), .q (q_w)
    );

    flopr #(.WIDTH(16), .STAGES(3)) dut_p (
        .clk (clk), .reset (rst_p), .d (d_p), .q (q_p)
    );

    flopr #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'hFF)) dut_f (
        .clk (clk), .reset (rst_f), .d (d_f), .q (q_f)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1, "watchdog expired");
    end

    // Reset held from time 0 with clocks running; q must stay 0 until the
    // first edge after release, which then captures A5.
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q_a !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: q=%h required 00", i, q_a);
            end
        end
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        n_cmp++;
        if (q_a !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_release: q=%h required 00", q_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q_a !== 8'hA5) begin
            n_bad++;
            $display("FAIL reset_first_edge: q=%h required a5", q_a);
        end
    endtask

    // d = 1..4 on successive edges; a mid-cycle change of d must not reach q.
    task automatic test_stream();
        logic [7:0] v;
        for (int i = 1; i <= 4; i++) begin
            v = 8'(i);
            @(negedge clk);
            d_a = v;
            @(posedge clk); #1;
            n_cmp++;
            if (q_a !== v) begin
                n_bad++;
                $display("FAIL stream_edge[%0d]: q=%h required %h", i, q_a, v);
            end
            #1 d_a = 8'hEE;
            #2;
            n_cmp++;
            if (q_a !== v) begin
                n_bad++;
                $display("FAIL stream_midcycle[%0d]: q=%h required %h", i, q_a, v);
            end
        end
    endtask

    // Reset asserted between edges must clear q without waiting for clk.
    task automatic test_async_reset();
        @(negedge clk);
        d_a = 8'h3C;
        @(posedge clk); #1;
        n_cmp++;
        if (q_a !== 8'h3C) begin
            n_bad++;
            $display("FAIL async_preload: q=%h required 3c", q_a);
        end
        #2 rst_a = 1'b1;
        #1;
        n_cmp++;
        if (q_a !== 8'h00) begin
            n_bad++;
            $display("FAIL async_immediate: q=%h required 00", q_a);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q_a !== 8'h00) begin
            n_bad++;
            $display("FAIL async_hold: q=%h required 00", q_a);
        end
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (q_a !== 8'h3C) begin
            n_bad++;
            $display("FAIL async_recover: q=%h required 3c", q_a);
        end
    endtask

    // 108-bit bundle must come through with every field in place.
    task automatic test_wide();
        logic [107:0] exp_w;
        exp_w = {32'hDEADBEEF, 32'h00000004, 32'h00001000, 5'd7, 7'b1010101};
        @(negedge clk);
        rst_w = 1'b0;
        d_w   = exp_w;
        #1;
        n_cmp++;
        if (q_w !== 108'd0) begin
            n_bad++;
            $display("FAIL wide_before_edge: q=%h required 0", q_w);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q_w !== exp_w) begin
            n_bad++;
            $display("FAIL wide_bundle: q=%h required %h", q_w, exp_w);
        end
        n_cmp++;
        if (q_w[107:76] !== 32'hDEADBEEF || q_w[75:44] !== 32'h00000004 ||
            q_w[43:12] !== 32'h00001000 || q_w[11:7] !== 5'd7 ||
            q_w[6:0] !== 7'b1010101) begin
            n_bad++;
            $display("FAIL wide_fields: q=%h required fields deadbeef/4/1000/7/55", q_w);
        end
    endtask

    // Three-stage latency, then a mid-pipeline reset that must flush all stages.
    task automatic test_pipeline();
        logic [15:0] exp_p [0:4];
        logic [15:0] din_p [0:4];
        din_p[0] = 16'h1111; din_p[1] = 16'h2222; din_p[2] = 16'h3333;
        din_p[3] = 16'h4444; din_p[4] = 16'h5555;
        exp_p[0] = 16'h0000; exp_p[1] = 16'h0000; exp_p[2] = 16'h1111;
        exp_p[3] = 16'h2222; exp_p[4] = 16'h3333;
        @(negedge clk);
        rst_p = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d_p = din_p[i];
            @(posedge clk); #1;
            n_cmp++;
            if (q_p !== exp_p[i]) begin
                n_bad++;
                $display("FAIL pipe_edge[%0d]: q=%h required %h", i + 1, q_p, exp_p[i]);
            end
        end
        // 4444 and 5555 are still in flight here.
        #2 rst_p = 1'b1;
        #1;
        n_cmp++;
        if (q_p !== 16'h0000) begin
            n_bad++;
            $display("FAIL pipe_flush_immediate: q=%h required 0000", q_p);
        end
        @(negedge clk);
        rst_p = 1'b0;
        d_p   = 16'h6666;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (q_p !== ((i == 2) ? 16'h6666 : 16'h0000)) begin
                n_bad++;
                $display("FAIL pipe_after_flush[%0d]: q=%h required %h", i + 1, q_p,
                         (i == 2) ? 16'h6666 : 16'h0000);
            end
        end
    endtask

    // Non-zero reset value; reset falling on a clk edge must win that edge.
    task automatic test_reset_value();
        @(negedge clk);
        d_f = 8'h00;
        #1;
        n_cmp++;
        if (q_f !== 8'hFF) begin
            n_bad++;
            $display("FAIL rv_reset: q=%h required ff", q_f);
        end
        @(posedge clk);
        // Nonblocking so the DUT still sees reset high on this very edge.
        rst_f <= 1'b0;
        #1;
        n_cmp++;
        if (q_f !== 8'hFF) begin
            n_bad++;
            $display("FAIL rv_coincident_edge: q=%h required ff", q_f);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (q_f !== 8'h00) begin
            n_bad++;
            $display("FAIL rv_first_capture: q=%h required 00", q_f);
        end
        @(negedge clk);
        d_f = 8'h5A;
        @(posedge clk); #1;
        n_cmp++;
        if (q_f !== 8'h5A) begin
            n_bad++;
            $display("FAIL rv_capture_5a: q=%h required 5a", q_f);
        end
        #2 rst_f = 1'b1;
        #1;
        n_cmp++;
        if (q_f !== 8'hFF) begin
            n_bad++;
            $display("FAIL rv_reassert: q=%h required ff", q_f);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b1; d_a = 8'hA5;
        rst_w = 1'b1; d_w = '0;
        rst_p = 1'b1; d_p = '0;
        rst_f = 1'b1; d_f = 8'h00;

        test_reset();
        test_stream();
        test_async_reset();
        test_wide();
        test_pipeline();
        test_reset_value();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
